// File: rtl/fpga_mini_project.sv
// DE1-SoC mini scope top: 640x480@60 VGA timing from the 50 MHz clock, colour bars / graticule / triangle trace.
// Optional feature macro BORDER_EN: white 1-pixel frame around the active area in every mode.
module fpga_mini_project #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       switch0,
    input  logic       switch1,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       VClock
);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_MID  = 10'(H_ACTIVE / 2);
    localparam logic [9:0] V_MID  = 10'(V_ACTIVE / 2);
    localparam logic [9:0] BAR_W  = 10'(H_ACTIVE / 8);
`ifdef BORDER_EN
    localparam logic BORDER = 1'b1;
`else
    localparam logic BORDER = 1'b0;
`endif

    logic [1:0]  sw_meta, sw_sync;
    logic [9:0]  h_count, v_count;
    logic [8:0]  phase;
    logic        h_wrap, v_wrap;
    logic        active, edge_px, grid, axis, trace;
    logic [8:0]  n;
    logic [7:0]  tri_val;
    logic [9:0]  trace_row;
    logic [2:0]  bar;
    logic [23:0] pix_p0;
    logic        hsync_p0, vsync_p0;

    assign h_wrap = (h_count == H_LAST);
    assign v_wrap = (v_count == V_LAST);

    // stage p0: decode colour and sync from the current counters
    always_comb begin
        n         = h_count[8:0] + phase;
        tri_val   = n[8] ? ~n[7:0] : n[7:0];
        trace_row = 10'd367 - {2'b00, tri_val};
        active    = (h_count < H_ACT) && (v_count < V_ACT);
        edge_px   = (h_count == 10'd0) || (h_count == H_ACT - 10'd1) ||
                    (v_count == 10'd0) || (v_count == V_ACT - 10'd1);
        grid      = (h_count[5:0] == 6'd0) || ((v_count % 10'd60) == 10'd0) ||
                    (h_count == H_ACT - 10'd1) || (v_count == V_ACT - 10'd1);
        axis      = (h_count == H_MID) || (v_count == V_MID);
        trace     = sw_sync[1] && (v_count == trace_row);
        bar       = 3'(h_count / BAR_W);
        hsync_p0  = !((h_count >= HS_BEG) && (h_count <= HS_END));
        vsync_p0  = !((v_count >= VS_BEG) && (v_count <= VS_END));
        pix_p0    = 24'h000000;
        if (!active) begin
            pix_p0 = 24'h000000;
        end else if (BORDER && edge_px) begin
            pix_p0 = 24'hFFFFFF;
        end else if (sw_sync == 2'b00) begin
            case (bar)
                3'd0:    pix_p0 = 24'hFFFFFF;
                3'd1:    pix_p0 = 24'hFFFF00;
                3'd2:    pix_p0 = 24'h00FFFF;
                3'd3:    pix_p0 = 24'h00FF00;
                3'd4:    pix_p0 = 24'hFF00FF;
                3'd5:    pix_p0 = 24'hFF0000;
                3'd6:    pix_p0 = 24'h0000FF;
                default: pix_p0 = 24'h000000;
            endcase
        end else if (trace) begin
            pix_p0 = 24'hFFFF00;
        end else if (axis) begin
            pix_p0 = 24'h00A000;
        end else if (grid) begin
            pix_p0 = 24'h004000;
        end
    end

    // stage p1: everything advances on the pixel tick (VClock high), except the divider and synchroniser
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            VClock    <= 1'b0;
            sw_meta   <= 2'b00;
            sw_sync   <= 2'b00;
            h_count   <= 10'd0;
            v_count   <= 10'd0;
            phase     <= 9'd0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            R         <= 8'd0;
            G         <= 8'd0;
            B         <= 8'd0;
        end else begin
            VClock  <= ~VClock;
            sw_meta <= {switch1, switch0};
            sw_sync <= sw_meta;
            if (VClock) begin
                h_count <= h_wrap ? 10'd0 : h_count + 10'd1;
                if (h_wrap) begin
                    v_count <= v_wrap ? 10'd0 : v_count + 10'd1;
                end
                if (h_wrap && v_wrap && (sw_sync == 2'b11)) begin
                    phase <= phase + 9'd1;
                end
                vga_hsync <= hsync_p0;
                vga_vsync <= vsync_p0;
                {R, G, B} <= pix_p0;
            end
        end
    end
endmodule

// File: tb/tb_fpga_mini_project.sv
// Bench for fpga_mini_project: full-size instance plus a narrow-line instance so whole frames fit in the run.
module tb_fpga_mini_project;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] sw_a = 2'b00;
    logic [1:0] sw_b = 2'b11;

    logic       hs_a, vs_a, vclk_a, hs_b, vs_b, vclk_b;
    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;

    int total = 0;
    int bad   = 0;

    always #10 clock = ~clock;

    fpga_mini_project dut_a (
        .clock(clock), .reset_n(reset_n), .switch0(sw_a[0]), .switch1(sw_a[1]),
        .vga_hsync(hs_a), .vga_vsync(vs_a), .R(r_a), .G(g_a), .B(b_a), .VClock(vclk_a)
    );

    fpga_mini_project #(.H_ACTIVE(16), .H_FP(1), .H_SYNC(2), .H_BP(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .switch0(sw_b[0]), .switch1(sw_b[1]),
        .vga_hsync(hs_b), .vga_vsync(vs_b), .R(r_b), .G(g_b), .B(b_b), .VClock(vclk_b)
    );

    // Timing of the two instances
    int HA [2] = '{640, 16};
    int HF [2] = '{16, 1};
    int HSY[2] = '{96, 2};
    int HB [2] = '{48, 1};
    localparam int VA = 480, VT = 525, VS0 = 490, VS1 = 491;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] model_rgb(input int ha, input int h, input int v,
                                              input logic [1:0] sw, input int ph);
        int nn, tv, row;
        if (h >= ha || v >= VA) return 24'h000000;
`ifdef BORDER_EN
        if (h == 0 || h == ha - 1 || v == 0 || v == VA - 1) return 24'hFFFFFF;
`endif
        if (sw == 2'b00) begin
            case (h / (ha / 8))
                0: return 24'hFFFFFF;
                1: return 24'hFFFF00;
                2: return 24'h00FFFF;
                3: return 24'h00FF00;
                4: return 24'hFF00FF;
                5: return 24'hFF0000;
                6: return 24'h0000FF;
                default: return 24'h000000;
            endcase
        end
        nn  = (h + ph) % 512;
        tv  = (nn < 256) ? nn : 511 - nn;
        row = 367 - tv;
        if (sw[1] && v == row) return 24'hFFFF00;
        if (h == ha / 2 || v == VA / 2) return 24'h00A000;
        if (h % 64 == 0 || v % 60 == 0 || h == ha - 1 || v == VA - 1) return 24'h004000;
        return 24'h000000;
    endfunction

    // Behavioural model: pixel index since reset release gives the raster position directly
    logic        m_vclk[2] = '{1'b0, 1'b0};
    logic        m_hs  [2] = '{1'b1, 1'b1};
    logic        m_vs  [2] = '{1'b1, 1'b1};
    logic [23:0] m_rgb [2] = '{24'h0, 24'h0};
    logic [1:0]  m_s1  [2] = '{2'b00, 2'b00};
    logic [1:0]  m_s2  [2] = '{2'b00, 2'b00};
    int          m_pix [2] = '{0, 0};
    int          m_ph  [2] = '{0, 0};

    initial forever begin
        @(posedge clock or negedge reset_n);
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_vclk[i] = 1'b0; m_hs[i] = 1'b1; m_vs[i] = 1'b1; m_rgb[i] = 24'h0;
                m_s1[i] = 2'b00; m_s2[i] = 2'b00; m_pix[i] = 0; m_ph[i] = 0;
            end else begin
                logic [1:0] eff;
                int ht, h, v;
                eff     = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = (i == 0) ? sw_a : sw_b;
                if (m_vclk[i]) begin
                    ht       = HA[i] + HF[i] + HSY[i] + HB[i];
                    h        = m_pix[i] % ht;
                    v        = (m_pix[i] / ht) % VT;
                    m_hs[i]  = !(h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HSY[i]);
                    m_vs[i]  = !(v >= VS0 && v <= VS1);
                    m_rgb[i] = model_rgb(HA[i], h, v, eff, m_ph[i]);
                    if (h == ht - 1 && v == VT - 1 && eff == 2'b11) m_ph[i] = (m_ph[i] + 1) % 512;
                    m_pix[i]++;
                end
                m_vclk[i] = !m_vclk[i];
            end
        end
    end

    bit cmp_en = 0;
    initial forever begin
        @(negedge clock);
        if (cmp_en) begin
            chk("out_a", {5'b0, vclk_a, hs_a, vs_a, r_a, g_a, b_a},
                {5'b0, m_vclk[0], m_hs[0], m_vs[0], m_rgb[0]});
            chk("out_b", {5'b0, vclk_b, hs_b, vs_b, r_b, g_b, b_b},
                {5'b0, m_vclk[1], m_hs[1], m_vs[1], m_rgb[1]});
        end
    end

    // Finds fall, rise, fall of a sync line; reports low width and period in clocks
    task automatic measure(input int sel, output int width, output int period, output bit ok);
        logic prev, cur;
        int   tf0, tr, stage;
        tf0 = 0; tr = 0; stage = 0; ok = 0; width = 0; period = 0;
        prev = sel ? vs_b : hs_a;
        for (int k = 0; k < 60000 && !ok; k++) begin
            @(negedge clock);
            cur = sel ? vs_b : hs_a;
            if (stage == 0 && prev && !cur) begin
                tf0 = k; stage = 1;
            end else if (stage == 1 && !prev && cur) begin
                tr = k; stage = 2;
            end else if (stage == 2 && prev && !cur) begin
                width = tr - tf0; period = k - tf0; ok = 1;
            end
            prev = cur;
        end
    endtask

    initial begin
        // Pin the model against hand-derived pixels
        chk("pin_bar85",   model_rgb(640, 85, 10, 2'b00, 0), 24'hFFFF00);
        chk("pin_bar520",  model_rgb(640, 520, 10, 2'b00, 0), 24'h0000FF);
        chk("pin_bar600",  model_rgb(640, 600, 10, 2'b00, 0), 24'h000000);
        chk("pin_blank",   model_rgb(640, 700, 10, 2'b00, 0), 24'h000000);
        chk("pin_tr255",   model_rgb(640, 255, 112, 2'b10, 0), 24'hFFFF00);
        chk("pin_axis",    model_rgb(640, 320, 100, 2'b10, 0), 24'h00A000);
        chk("pin_grid",    model_rgb(640, 64, 10, 2'b01, 0), 24'h004000);
`ifdef BORDER_EN
        chk("pin_border",  model_rgb(640, 0, 200, 2'b10, 0), 24'hFFFFFF);
`else
        chk("pin_bar0",    model_rgb(640, 0, 10, 2'b00, 0), 24'hFFFFFF);
        chk("pin_tr0",     model_rgb(640, 0, 367, 2'b10, 0), 24'hFFFF00);
        chk("pin_tr0_ph2", model_rgb(640, 0, 365, 2'b11, 2), 24'hFFFF00);
`endif

        @(negedge clock);
        cmp_en = 1;
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        repeat (3000) @(negedge clock);

        // Mid-frame asynchronous reset
        #3 reset_n = 1'b0;
        #1;
        chk("rst_vclk_a", {31'b0, vclk_a}, 32'd0);
        chk("rst_sync_a", {30'b0, hs_a, vs_a}, 32'd3);
        chk("rst_rgb_a",  {8'b0, r_a, g_a, b_a}, 32'd0);
        chk("rst_vclk_b", {31'b0, vclk_b}, 32'd0);
        chk("rst_sync_b", {30'b0, hs_b, vs_b}, 32'd3);
        chk("rst_rgb_b",  {8'b0, r_b, g_b, b_b}, 32'd0);
        repeat (5) @(negedge clock);
        reset_n = 1'b1;

        fork
            begin
                int w, p; bit ok;
                measure(0, w, p, ok);
                chk("hsync_found", {31'b0, ok}, 32'd1);
                if (ok) begin
                    chk("hsync_width", w, 32'd192);
                    chk("hsync_period", p, 32'd1600);
                end
            end
            begin
                int w, p; bit ok;
                measure(1, w, p, ok);
                chk("vsync_found", {31'b0, ok}, 32'd1);
                if (ok) begin
                    chk("vsync_width", w, 32'd80);
                    chk("vsync_period", p, 32'd21000);
                end
            end
        join_none

        for (int c = 0; c < 66000; c++) begin
            @(negedge clock);
            if (c >= 20000 && c % 2500 == 0) sw_a = 2'($urandom_range(0, 3));
            if (c == 50000) begin
                chk("phase_run2", {23'b0, dut_b.phase}, 32'd2);
                sw_b = 2'b10;
            end
        end
        chk("phase_hold", {23'b0, dut_b.phase}, 32'd2);
        chk("phase_model", {23'b0, dut_b.phase}, m_ph[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
